lsu_subword: RTL and testbench
==============================

Name: lsu_subword

Overview:
- Load/store unit placed directly upstream of the word-wide data memory (`dmem`). The memory offers only a combinational word read and a whole-word write on `clk`.
- On loads, the block selects the addressed byte or halfword and sign- or zero-extends it.
- On byte and halfword stores, it performs a read-modify-write so the other bytes of the word are preserved.
- It also flags misaligned, out-of-range and illegal accesses.
- The core talks to it through a valid/ready request and a one-cycle response pulse.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the attached `dmem`. Byte addresses at or above MEM_WORDS*4 are out of range.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I load/store funct3
- req_address  input  32  byte address
- req_write_data  input  32  store data, right-justified
- resp_valid  output  1  one-cycle response pulse
- resp_read_data  output  32  extended load result; 0 for stores and errors
- resp_error  output  1  access rejected, no memory write performed
- data_mem_write_enable  output  1  to `dmem`
- data_mem_address  output  32  to `dmem`, word aligned
- data_mem_write_data  output  32  to `dmem`
- data_mem_read_data  input  32  from `dmem`, combinational read

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - resp_valid, resp_error and resp_read_data all 0.
  - Latched request registers cleared to 0.
  - data_mem_write_enable is 0 while in reset.
  - Reset mid-operation abandons the access. A pending RMW write is never issued and no response is produced.
- States:
  - IDLE:
    - req_ready = 1.
    - On req_valid && req_ready: latch write, funct3, address and data.
    - If the request is illegal, go to RESP with the error set. Otherwise go to ACCESS.
  - ACCESS:
    - Load: capture data_mem_read_data, extract the addressed field and extend it into the result register. Go to RESP.
    - SW: data_mem_write_enable = 1 with data_mem_write_data = latched data. Go to RESP.
    - SB/SH: capture data_mem_read_data into a merge register. Go to WRITE.
  - WRITE:
    - data_mem_write_enable = 1.
    - data_mem_write_data = captured word with only the target byte or halfword replaced by the low bits of the store data.
    - Go to RESP.
  - RESP:
    - resp_valid = 1 for exactly one cycle. Go to IDLE.
    - req_ready = 0 in every state except IDLE.
- Memory interface:
  - data_mem_address = {latched_address[31:2], 2'b00} in ACCESS and WRITE; 0 otherwise.
  - data_mem_write_enable is 1 only in the states named above, never in IDLE or RESP.
  - data_mem_write_data is 0 when write enable is low.
- funct3 decoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Illegal request (resp_error = 1 in RESP, resp_read_data = 0, no write) if any of:
  - funct3 is illegal;
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - address >= MEM_WORDS*4.
- Byte lanes are little-endian: addr[1:0] = 0 selects bits [7:0], 3 selects bits [31:24]. Halfword at addr[1] = 1 selects bits [31:16].
- Latency, request accepted at cycle N:
  - Error: resp_valid at N+1.
  - Load and SW: resp_valid at N+2; the SW write occurs on the edge ending N+1.
  - SB/SH: write on the edge ending N+2; resp_valid at N+3.
- resp_read_data and resp_error are held from RESP until the next RESP or reset.
- A request presented while req_ready = 0 is ignored. The requester must hold it until accepted.

Test Plan:
- Reset with rst_n low mid-WRITE of an SB → no write is issued; req_ready = 1; resp outputs 0 after release.
- Preload word 4 = 0x8899AABB. LB addr 0x11 → resp_read_data 0xFFFFFFAA. LBU addr 0x11 → 0x000000AA. LH addr 0x12 → 0xFFFF8899. LW addr 0x10 → 0x8899AABB. Each response at N+2.
- Word 4 = 0x8899AABB. SB addr 0x12 data 0x12345677 → word 4 = 0x8877AABB after the write; resp at N+3. SH addr 0x10 data 0xCAFE → word 4 = 0x8877CAFE.
- SW addr 0x20 data 0xDEADBEEF → word 8 = 0xDEADBEEF; resp_valid at N+2; exactly one write-enable cycle.
- Each of LH addr 0x03, LW addr 0x02, funct3 011, and SW addr 0x100 (MEM_WORDS = 64) → resp_error = 1 at N+1; memory contents unchanged.
- Back-to-back requests with req_valid held high → req_ready low from N+1 until the response completes; the second request is accepted the cycle after RESP; no request lost or duplicated.

Source files
------------

// File: rtl/lsu_subword.sv
// Sub-word load/store unit in front of a word-wide dmem with combinational read.
// Extracts and extends loads, does read-modify-write for byte/halfword stores.
module lsu_subword #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        resp_valid,
    output logic [31:0] resp_read_data,
    output logic        resp_error,
    output logic        data_mem_write_enable,
    output logic [31:0] data_mem_address,
    output logic [31:0] data_mem_write_data,
    input  logic [31:0] data_mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] address;
        logic [31:0] data;
    } req_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    function automatic logic req_illegal(input req_t r);
        logic bad_f3;
        logic misalign;
        logic out_of_range;
        if (r.write)
            bad_f3 = !(r.funct3 inside {3'b000, 3'b001, 3'b010});
        else
            bad_f3 = !(r.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misalign = ((r.funct3[1:0] == 2'b01) && r.address[0]) ||
                   ((r.funct3[1:0] == 2'b10) && (r.address[1:0] != 2'b00));
        out_of_range = (r.address >= ADDR_LIMIT);
        return bad_f3 || misalign || out_of_range;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'h0, b};
            3'b101:  res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed byte/halfword; the rest comes from the captured word.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic [15:0] d);
        logic [31:0] res;
        res = word;
        if (size == 2'b00) begin
            case (lane)
                2'd0:    res[7:0]   = d[7:0];
                2'd1:    res[15:8]  = d[7:0];
                2'd2:    res[23:16] = d[7:0];
                default: res[31:24] = d[7:0];
            endcase
        end else if (lane[1]) begin
            res[31:16] = d;
        end else begin
            res[15:0] = d;
        end
        return res;
    endfunction

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] resp_read_data_q, resp_read_data_d;
    logic        resp_error_q, resp_error_d;
    req_t        req_in;

    assign req_in = '{write:   req_write,
                      funct3:  req_funct3,
                      address: req_address,
                      data:    req_write_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            req_q            <= '0;
            merge_q          <= '0;
            resp_read_data_q <= '0;
            resp_error_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            merge_q          <= merge_d;
            resp_read_data_q <= resp_read_data_d;
            resp_error_q     <= resp_error_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        req_d                 = req_q;
        merge_d               = merge_q;
        resp_read_data_d      = resp_read_data_q;
        resp_error_d          = resp_error_q;
        req_ready             = 1'b0;
        data_mem_write_enable = 1'b0;
        data_mem_address      = '0;
        data_mem_write_data   = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_d = req_in;
                    if (req_illegal(req_in)) begin
                        resp_error_d     = 1'b1;
                        resp_read_data_d = '0;
                        state_d          = S_RESP;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                data_mem_address = {req_q.address[31:2], 2'b00};
                if (!req_q.write) begin
                    resp_read_data_d = load_extract(data_mem_read_data, req_q.funct3,
                                                    req_q.address[1:0]);
                    resp_error_d     = 1'b0;
                    state_d          = S_RESP;
                end else if (req_q.funct3[1:0] == 2'b10) begin
                    data_mem_write_enable = 1'b1;
                    data_mem_write_data   = req_q.data;
                    resp_read_data_d      = '0;
                    resp_error_d          = 1'b0;
                    state_d               = S_RESP;
                end else begin
                    merge_d = data_mem_read_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                data_mem_address      = {req_q.address[31:2], 2'b00};
                data_mem_write_enable = 1'b1;
                data_mem_write_data   = store_merge(merge_q, req_q.funct3[1:0],
                                                    req_q.address[1:0], req_q.data[15:0]);
                resp_read_data_d      = '0;
                resp_error_d          = 1'b0;
                state_d               = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign resp_valid     = (state_q == S_RESP);
    assign resp_read_data = resp_read_data_q;
    assign resp_error     = resp_error_q;

endmodule

// File: tb/tb_lsu_subword.sv
// Scoreboard bench for lsu_subword with a behavioural word memory.
module tb_lsu_subword;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_address = 32'h0;
    logic [31:0] req_write_data = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_read_data;
    logic        resp_error;
    logic        data_mem_write_enable;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_write_data;
    logic [31:0] data_mem_read_data;

    always #5 clk = ~clk;

    lsu_subword #(.MEM_WORDS(64)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_write             (req_write),
        .req_funct3            (req_funct3),
        .req_address           (req_address),
        .req_write_data        (req_write_data),
        .resp_valid            (resp_valid),
        .resp_read_data        (resp_read_data),
        .resp_error            (resp_error),
        .data_mem_write_enable (data_mem_write_enable),
        .data_mem_address      (data_mem_address),
        .data_mem_write_data   (data_mem_write_data),
        .data_mem_read_data    (data_mem_read_data)
    );

    logic [31:0] mem [64] = '{default: 32'h0};
    logic        tb_we = 1'b0;
    logic [5:0]  tb_idx = 6'd0;
    logic [31:0] tb_val = 32'h0;
    int          cyc = 0;
    int          we_cnt = 0;
    int          last_we_cyc = -1;

    assign data_mem_read_data = mem[data_mem_address[7:2]];

    always @(posedge clk) begin
        if (data_mem_write_enable) begin
            mem[data_mem_address[7:2]] <= data_mem_write_data;
            we_cnt      <= we_cnt + 1;
            last_we_cyc <= cyc;
        end else if (tb_we) begin
            mem[tb_idx] <= tb_val;
        end
        cyc <= cyc + 1;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic        busy = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;

    // Response monitor: pops the scoreboard, checks timing, hold and interface rules.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_rdata = 32'h0;
                last_err   = 1'b0;
            end else begin
                checks++;
                if (!data_mem_write_enable && data_mem_write_data !== 32'h0) begin
                    failures++;
                    $display("FAIL wdata_idle_zero got=%h want=0", data_mem_write_data);
                end
                checks++;
                if (data_mem_address[1:0] !== 2'b00) begin
                    failures++;
                    $display("FAIL addr_aligned got=%h", data_mem_address);
                end
                if (busy) begin
                    checks++;
                    if (req_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL ready_busy cyc=%0d got=%b want=0", cyc, req_ready);
                    end
                end
                if (resp_valid === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_resp cyc=%0d rdata=%h err=%b",
                                 cyc, resp_read_data, resp_error);
                    end else begin
                        e = sb.pop_front();
                        if (resp_read_data !== e.rdata || resp_error !== e.err ||
                            cyc != e.cyc) begin
                            failures++;
                            $display("FAIL resp got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                                     resp_read_data, resp_error, cyc, e.rdata, e.err, e.cyc);
                        end
                    end
                    last_rdata = resp_read_data;
                    last_err   = resp_error;
                    busy       = 1'b0;
                end else begin
                    checks++;
                    if (resp_read_data !== last_rdata || resp_error !== last_err) begin
                        failures++;
                        $display("FAIL resp_hold got rdata=%h err=%b want rdata=%h err=%b",
                                 resp_read_data, resp_error, last_rdata, last_err);
                    end
                end
            end
        end
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        tb_we  = 1'b1;
        tb_idx = idx;
        tb_val = val;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Presents a request and holds it until accepted; leaves req_valid asserted.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] er, input logic ee,
                         input int lat, output int n);
        exp_t e;
        req_valid      = 1'b1;
        req_write      = w;
        req_funct3     = f3;
        req_address    = a;
        req_write_data = d;
        n = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                n = cyc;
                break;
            end
        end
        checks++;
        if (n < 0) begin
            failures++;
            $display("FAIL accept_timeout addr=%h", a);
            req_valid = 1'b0;
            return;
        end
        e.rdata = er;
        e.err   = ee;
        e.cyc   = n + lat;
        sb.push_back(e);
        @(posedge clk);
        #1 busy = 1'b1;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
            sb.delete();
            busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_read_data !== 32'h0 ||
            req_ready !== 1'b1 || data_mem_write_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got valid=%b err=%b rdata=%h ready=%b we=%b want 0 0 0 1 0",
                     resp_valid, resp_error, resp_read_data, req_ready, data_mem_write_enable);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [4]  = '{3'b000, 3'b100, 3'b001, 3'b010};
        logic [31:0] ad [4]  = '{32'h11, 32'h11, 32'h12, 32'h10};
        logic [31:0] ex [4]  = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h8899AABB};
        int n;
        preload(6'd4, 32'h8899AABB);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3[i], ad[i], 32'h0, ex[i], 1'b0, 2, n);
            drain();
        end
    endtask

    task automatic test_subword_stores();
        int n;
        int w0;
        logic [2:0]  f3 [2] = '{3'b000, 3'b001};
        logic [31:0] ad [2] = '{32'h12, 32'h10};
        logic [31:0] dd [2] = '{32'h12345677, 32'h0000CAFE};
        logic [31:0] ex [2] = '{32'h8877AABB, 32'h8877CAFE};
        preload(6'd4, 32'h8899AABB);
        for (int i = 0; i < 2; i++) begin
            w0 = we_cnt;
            issue(1'b1, f3[i], ad[i], dd[i], 32'h0, 1'b0, 3, n);
            drain();
            checks++;
            if (mem[4] !== ex[i] || we_cnt - w0 != 1 || last_we_cyc != n + 2) begin
                failures++;
                $display("FAIL rmw_store%0d got word=%h writes=%0d wcyc=%0d want word=%h writes=1 wcyc=%0d",
                         i, mem[4], we_cnt - w0, last_we_cyc, ex[i], n + 2);
            end
        end
    endtask

    task automatic test_sw();
        int n;
        int w0;
        w0 = we_cnt;
        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, n);
        drain();
        checks++;
        if (mem[8] !== 32'hDEADBEEF || we_cnt - w0 != 1 || last_we_cyc != n + 1) begin
            failures++;
            $display("FAIL sw got word=%h writes=%0d wcyc=%0d want word=deadbeef writes=1 wcyc=%0d",
                     mem[8], we_cnt - w0, last_we_cyc, n + 1);
        end
    endtask

    task automatic test_errors();
        logic        wr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3 [5] = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b100};
        logic [31:0] ad [5] = '{32'h03, 32'h02, 32'h10, 32'h100, 32'h10};
        logic [31:0] m4, m8;
        int n;
        int w0;
        for (int i = 0; i < 5; i++) begin
            w0 = we_cnt;
            m4 = mem[4];
            m8 = mem[8];
            issue(wr[i], f3[i], ad[i], 32'h5A5A5A5A, 32'h0, 1'b1, 1, n);
            drain();
            checks++;
            if (we_cnt != w0 || mem[4] !== m4 || mem[8] !== m8) begin
                failures++;
                $display("FAIL err_nowrite%0d got writes=%0d want 0", i, we_cnt - w0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n0, n1, n2, n3, n4, n5;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8877CAFE, 1'b0, 2, n0);
        issue(1'b1, 3'b010, 32'h14, 32'hA5A5A5A5, 32'h0, 1'b0, 2, n1);
        issue(1'b0, 3'b100, 32'h15, 32'h0, 32'h000000A5, 1'b0, 2, n2);
        issue(1'b1, 3'b000, 32'h16, 32'h0000003C, 32'h0, 1'b0, 3, n3);
        issue(1'b0, 3'b010, 32'h15, 32'h0, 32'h0, 1'b1, 1, n4);
        issue(1'b0, 3'b010, 32'h14, 32'h0, 32'hA53CA5A5, 1'b0, 2, n5);
        drain();
        checks++;
        if (n1 != n0 + 3 || n2 != n1 + 3 || n3 != n2 + 3 || n4 != n3 + 4 || n5 != n4 + 2) begin
            failures++;
            $display("FAIL b2b_accept got %0d %0d %0d %0d %0d %0d want gaps 3 3 3 4 2",
                     n0, n1, n2, n3, n4, n5);
        end
    endtask

    task automatic test_reset_mid_write();
        int w0;
        preload(6'd6, 32'h01020304);
        w0 = we_cnt;
        req_valid      = 1'b1;
        req_write      = 1'b1;
        req_funct3     = 3'b000;
        req_address    = 32'h18;
        req_write_data = 32'h000000FF;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_accept got ready=%b want 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (data_mem_write_enable !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_in_write got we=%b want 1", data_mem_write_enable);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_mem_write_enable !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 ||
            resp_error !== 1'b0 || resp_read_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs got we=%b ready=%b valid=%b err=%b rdata=%h want 0 1 0 0 0",
                     data_mem_write_enable, req_ready, resp_valid, resp_error, resp_read_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mem[6] !== 32'h01020304 || we_cnt != w0 || req_ready !== 1'b1 ||
            resp_read_data !== 32'h0 || resp_error !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_after got word=%h writes=%0d ready=%b rdata=%h err=%b want 01020304 0 1 0 0",
                     mem[6], we_cnt - w0, req_ready, resp_read_data, resp_error);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_subword_stores();
        test_sw();
        test_errors();
        test_back_to_back();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
